sample_log_ctrl: RTL
====================

# sample_log_ctrl

Controller for the thermometer's 256 × 8 dual-port sample RAM. Treats the RAM as a circular log of temperature samples:
- Port A writes new samples from the sensor path.
- Port B zero-fills the whole array on reset and on clear.
- The combinational read port serves a pop interface for the display/UART path.

Owns all pointers, occupancy, overwrite-on-full policy and the clear sweep, so no other block drives the RAM.

## Interface
- DATA_W, 8, sample width; equals RAM word width
- DEPTH, 256, log entries; power of two, ≤ 2^ADDR_W
- ADDR_W, 9, RAM address port width; upper unused bits driven 0

- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- sample_data  in  DATA_W  sample to log
- sample_valid  in  1  sample offered this cycle
- sample_ready  out  1  controller accepts sample this cycle
- rd_req  in  1  pop oldest sample
- rd_data  out  DATA_W  popped sample, registered
- rd_valid  out  1  rd_data valid, 1-cycle pulse per pop
- clr_req  in  1  start clear sweep
- busy  out  1  clear sweep in progress
- count  out  ADDR_W  entries held, 0..DEPTH
- empty, full  out  1 each  count==0 / count==DEPTH
- overflow  out  1  sticky; an unread sample was overwritten
- ram_data_in  out  DATA_W  to RAM data_in
- ram_address_a, ram_address_b, ram_r_address  out  ADDR_W each  to RAM
- ram_ena, ram_enb  out  1 each  to RAM write enables
- ram_data_out  in  DATA_W  from RAM data_out

## Operation
- States: CLEAR, IDLE.
- Reset (reset==0 at edge):
  - state=CLEAR, clr_ptr=0, wr_ptr=rd_ptr=0, count=0.
  - overflow=0, rd_valid=0, rd_data=0.
- Outputs while reset is held: busy=1, sample_ready=0.
- CLEAR:
  - ram_enb=1, ram_address_b=clr_ptr; clr_ptr increments each cycle.
  - At clr_ptr==DEPTH-1, the next state is IDLE, and wr_ptr, rd_ptr, count and overflow are all 0.
  - Sweep lasts exactly DEPTH cycles.
  - sample_ready=0, ram_ena=0, rd_req ignored, clr_req ignored.
- IDLE → CLEAR on clr_req (clr_ptr=0); the clear has priority over any push or pop in the same cycle.
- IDLE push (accepted = sample_valid && sample_ready; sample_ready=1 in IDLE with no clr_req):
  - Combinational outputs: ram_ena=1, ram_address_a=wr_ptr, ram_data_in=sample_data.
  - At the edge: wr_ptr+1 mod DEPTH.
- IDLE pop (rd_req && !empty):
  - ram_r_address=rd_ptr; ram_r_address is always driven to rd_ptr.
  - At the edge: rd_data<=ram_data_out, rd_valid<=1, rd_ptr+1 mod DEPTH.
  - rd_req while empty: no effect, rd_valid=0.
- count rules:
  - push only: +1, unless full.
  - pop only: −1.
  - push+pop: unchanged.
- Full, push, no pop:
  - Sample is written at wr_ptr (==rd_ptr).
  - Both pointers advance, count stays DEPTH, overflow<=1.
- Full, push+pop: the pop reads the old word at rd_ptr, then the write lands on the same edge. Both pointers advance and overflow is unchanged.
- ram_ena and ram_enb are never 1 in the same cycle.
- Pointer arithmetic is log2(DEPTH) bits with natural wrap; ram addresses are zero-extended to ADDR_W.

## Timing
- Push latency: the sample is in RAM at the accepting edge; it is readable by a pop in the following cycle.
- Pop latency: rd_valid/rd_data one cycle after the rd_req edge. Back-to-back pops are supported at 1 per cycle.
- Clear: busy rises the cycle after the clr_req edge and stays high DEPTH cycles. The first push is accepted in the cycle busy falls.
- After reset deassertion: busy=1 for DEPTH cycles, then IDLE with empty=1.
- Reset mid-sweep or mid-traffic: the sweep restarts from address 0 and all state is discarded.
- count, empty, full, overflow are registered. sample_ready and the ram_* controls are combinational from state and inputs.

## Test plan
- Reset released, run 256 cycles: busy high exactly 256 cycles, ram_enb sweeps 0..255, then empty=1 and count=0. A RAM model reads all 0x00.
- Push 0x10,0x11,0x12, then pop 3 back-to-back: rd_data 0x10,0x11,0x12 on consecutive cycles, rd_valid 3 cycles, empty=1 after.
- Push 256 samples 0x00..0xFF: full=1, count=256. Push 0xAA: overflow=1, count=256. Pop: rd_data=0x01, and the last popped entry is 0xAA.
- Full, push 0x55 with simultaneous rd_req: rd_data=oldest value, count stays 256, overflow stays 0.
- Empty, pop: rd_valid=0 and count=0. Then push+pop in the same cycle on an empty log: only the push takes effect, count=1.
- Mid-traffic (count=5), assert clr_req together with sample_valid: sample not written, ram_ena never 1 during sweep. After 256 cycles count=0, overflow=0. Repeat with reset low mid-sweep and check the sweep restarts at address 0.

Source files
------------

// File: rtl/sample_log_ctrl.sv
// sample_log_ctrl: circular sample log over a 256x8 dual-port RAM with zero-fill clear sweep
module sample_log_ctrl #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic              rd_req,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic [DATA_W-1:0] ram_data_in,
  output logic [ADDR_W-1:0] ram_address_a,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic [ADDR_W-1:0] ram_r_address,
  output logic              ram_ena,
  output logic              ram_enb,
  input  logic [DATA_W-1:0] ram_data_out
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [PW-1:0] clr_ptr, wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] count_n;
  logic push, pop, sweep_done;
  assign ram_address_a = ADDR_W'(wr_ptr);
  assign ram_address_b = ADDR_W'(clr_ptr);
  assign ram_r_address = ADDR_W'(rd_ptr);
  assign ram_data_in   = ram_ena ? sample_data : '0;
  assign sweep_done    = state == CLEAR && clr_ptr == PW'(DEPTH - 1);
  // state register; reset always restarts the sweep
  always_ff @(posedge clk)
    state <= !reset ? CLEAR : state_n;
  // next state, handshake and RAM enables; clear beats push/pop
  always_comb begin
    state_n      = state;
    busy         = !reset || state == CLEAR;
    sample_ready = 1'b0;
    ram_ena      = 1'b0;
    ram_enb      = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    if (state == CLEAR) begin
      ram_enb = reset;
      if (sweep_done) state_n = IDLE;
    end else if (clr_req) begin
      state_n = CLEAR;
    end else begin
      sample_ready = reset;
      push         = reset && sample_valid;
      pop          = reset && rd_req && !empty;
      ram_ena      = push;
    end
    count_n = (push && !pop && !full) ? count + 1'b1 :
              (pop && !push)          ? count - 1'b1 : count;
  end
  // sweep address: parked at 0 outside the sweep so every clear starts at 0
  always_ff @(posedge clk)
    clr_ptr <= (!reset || state == IDLE) ? '0 : clr_ptr + 1'b1;
  // pointers and occupancy; a push into a full log drops the oldest entry
  always_ff @(posedge clk) begin
    if (!reset || sweep_done) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && full && !pop) overflow <= 1'b1;
      count <= count_n;
      empty <= count_n == '0;
      full  <= count_n == ADDR_W'(DEPTH);
    end
  end
  // registered pop output
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= ram_data_out;
    end
  end
endmodule
